ka_12bit_seq_ctrl: RTL and testbench

//  Sequencer that computes a 12x12 GF(2)[x] (carry-less) product by time-multiplexing ONE

---
 rtl/ka_12bit_seq_ctrl_if.sv | 21 ++
 rtl/ka_12bit_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_ka_12bit_seq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ka_12bit_seq_ctrl_if.sv
// Operand/result valid-ready bundle for the 12-bit carry-less sequencer.
// master = operand source / result sink, slave = the sequencer.
interface ka_12bit_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a;
  logic [11:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] y;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/ka_12bit_seq_ctrl.sv
// 12x12 carry-less multiplier sequencer: one 6-bit Karatsuba core reused
// over low, high and middle slots, partials folded into a 23-bit accumulator.
module ka_12bit_seq_ctrl #(
  parameter bit REG_CORE_OUT = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  ka_12bit_seq_ctrl_if.slave        bus,
  output logic                      busy,
  output logic [5:0]                core_a,
  output logic [5:0]                core_b,
  input  logic [10:0]               core_y
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LO    = 3'd1;
  localparam logic [2:0] S_HI    = 3'd2;
  localparam logic [2:0] S_MID   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_L    = 2'd1;
  localparam logic [1:0] K_H    = 2'd2;
  localparam logic [1:0] K_M    = 2'd3;

  logic [2:0]  state_q, state_d;
  logic [11:0] ar_q, ar_d;
  logic [11:0] br_q, br_d;
  logic [22:0] acc_q, acc_d;
  logic [5:0]  ca_q, ca_d;
  logic [5:0]  cb_q, cb_d;
  logic [10:0] py_q, py_d;
  logic [1:0]  pk_q, pk_d;

  logic        accept;
  logic        retire;
  logic [1:0]  sk;
  logic [1:0]  fk;
  logic [10:0] fv;
  logic [22:0] fold;

  assign bus.in_ready  = (state_q == S_IDLE) |
                         ((state_q == S_DONE) & bus.out_ready);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.y         = acc_q;
  assign busy          = (state_q != S_IDLE);
  assign core_a        = ca_q;
  assign core_b        = cb_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign retire = (state_q == S_DONE) & bus.out_ready;

  always_comb begin
    sk = K_NONE;
    unique case (1'b1)
      (state_q == S_LO):  sk = K_L;
      (state_q == S_HI):  sk = K_H;
      (state_q == S_MID): sk = K_M;
      default:            sk = K_NONE;
    endcase
  end

  // With a registered core output the partial is folded one cycle late,
  // tagged by the slot that issued it.
  assign fk = REG_CORE_OUT ? pk_q : sk;
  assign fv = REG_CORE_OUT ? py_q : core_y;

  always_comb begin
    fold = 23'd0;
    unique case (1'b1)
      (fk == K_L): fold = {6'd0, fv, 6'd0} ^ {12'd0, fv};
      (fk == K_H): fold = {6'd0, fv, 6'd0} ^ {fv, 12'd0};
      (fk == K_M): fold = {6'd0, fv, 6'd0};
      default:     fold = 23'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ar_d    = ar_q;
    br_d    = br_q;
    acc_d   = acc_q ^ fold;
    ca_d    = ca_q;
    cb_d    = cb_q;
    py_d    = core_y;
    pk_d    = sk;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = S_LO;
          ar_d    = bus.a;
          br_d    = bus.b;
          acc_d   = 23'd0;
          ca_d    = bus.a[5:0];
          cb_d    = bus.b[5:0];
        end else if (retire) begin
          state_d = S_IDLE;
        end
      end
      S_LO: begin
        state_d = S_HI;
        ca_d    = ar_q[11:6];
        cb_d    = br_q[11:6];
      end
      S_HI: begin
        state_d = S_MID;
        ca_d    = ar_q[5:0] ^ ar_q[11:6];
        cb_d    = br_q[5:0] ^ br_q[11:6];
      end
      S_MID: begin
        state_d = REG_CORE_OUT ? S_DRAIN : S_DONE;
        ca_d    = 6'd0;
        cb_d    = 6'd0;
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        ca_d    = 6'd0;
        cb_d    = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ar_q    <= 12'd0;
      br_q    <= 12'd0;
      acc_q   <= 23'd0;
      ca_q    <= 6'd0;
      cb_q    <= 6'd0;
      py_q    <= 11'd0;
      pk_q    <= K_NONE;
    end else if (flush) begin
      state_q <= S_IDLE;
      acc_q   <= 23'd0;
      ca_q    <= 6'd0;
      cb_q    <= 6'd0;
      py_q    <= 11'd0;
      pk_q    <= K_NONE;
    end else begin
      state_q <= state_d;
      ar_q    <= ar_d;
      br_q    <= br_d;
      acc_q   <= acc_d;
      ca_q    <= ca_d;
      cb_q    <= cb_d;
      py_q    <= py_d;
      pk_q    <= pk_d;
    end
  end

endmodule

// File: tb/tb_ka_12bit_seq_ctrl.sv
// Bench for ka_12bit_seq_ctrl: both REG_CORE_OUT builds, directed steps
// plus a random scoreboard run against a bit-serial carry-less model.
module tb_ka_12bit_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic flush;
  logic sel;
  logic iv;
  logic orv;
  logic [11:0] av;
  logic [11:0] bv;

  ka_12bit_seq_ctrl_if if0 ();
  ka_12bit_seq_ctrl_if if1 ();

  logic        busy0, busy1;
  logic [5:0]  ca0, cb0, ca1, cb1;
  logic [10:0] cy0, cy1;

  function automatic logic [10:0] clmul6(logic [5:0] x, logic [5:0] z);
    logic [10:0] r;
    r = 11'd0;
    for (int i = 0; i < 6; i++)
      if (z[i]) r = r ^ (11'(x) << i);
    return r;
  endfunction

  function automatic logic [22:0] clmul12(logic [11:0] x, logic [11:0] z);
    logic [22:0] r;
    r = 23'd0;
    for (int i = 0; i < 12; i++)
      if (z[i]) r = r ^ (23'(x) << i);
    return r;
  endfunction

  assign cy0 = clmul6(ca0, cb0);
  assign cy1 = clmul6(ca1, cb1);

  ka_12bit_seq_ctrl #(.REG_CORE_OUT(1'b0)) u0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .bus    (if0.slave),
    .busy   (busy0),
    .core_a (ca0),
    .core_b (cb0),
    .core_y (cy0)
  );

  ka_12bit_seq_ctrl #(.REG_CORE_OUT(1'b1)) u1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .bus    (if1.slave),
    .busy   (busy1),
    .core_a (ca1),
    .core_b (cb1),
    .core_y (cy1)
  );

  always_comb begin
    if0.in_valid  = iv & ~sel;
    if1.in_valid  = iv & sel;
    if0.a         = av;
    if1.a         = av;
    if0.b         = bv;
    if1.b         = bv;
    if0.out_ready = sel ? 1'b1 : orv;
    if1.out_ready = sel ? orv : 1'b1;
  end

  logic        o_valid, o_ready, o_busy;
  logic [22:0] o_y;
  logic [5:0]  o_ca, o_cb;

  always_comb begin
    o_valid = sel ? if1.out_valid : if0.out_valid;
    o_ready = sel ? if1.in_ready : if0.in_ready;
    o_y     = sel ? if1.y : if0.y;
    o_busy  = sel ? busy1 : busy0;
    o_ca    = sel ? ca1 : ca0;
    o_cb    = sel ? cb1 : cb0;
  end

  int checks = 0;
  int failures = 0;
  logic [22:0] q[$];
  logic accepted;
  int ncyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cfg=%0d observed=%h expected=%h",
             tag, sel, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [11:0] x,
                     input logic [11:0] z, input logic r,
                     input logic f, input logic n);
    iv = v; av = x; bv = z; orv = r; flush = f; rst_n = n;
    #1;
    accepted = 1'b0;
    if (!n || f) begin
      q.delete();
    end else begin
      if (o_valid && r) begin
        chk("sb_pending", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) chk("sb_y", 32'(o_y), 32'(q.pop_front()));
      end
      if (v && o_ready) begin
        q.push_back(clmul12(x, z));
        accepted = 1'b1;
      end
    end
    ncyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!o_valid && n < 20) begin
      cyc(1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    chk(tag, 32'(o_valid), 32'd1);
  endtask

  task automatic op(input logic [11:0] x, input logic [11:0] z,
                    input logic [22:0] ey, input string tag);
    int lat;
    int bc;
    cyc(1'b1, x, z, 1'b0, 1'b0, 1'b1);
    chk({tag, "_core_a_lo"}, 32'(o_ca), 32'(x[5:0]));
    chk({tag, "_core_b_lo"}, 32'(o_cb), 32'(z[5:0]));
    lat = 1;
    bc = 0;
    while (!o_valid && lat < 20) begin
      bc += int'(o_busy);
      cyc(1'b0, ~x, ~z, 1'b0, 1'b0, 1'b1);
      lat++;
    end
    bc += int'(o_busy);
    chk({tag, "_latency"}, 32'(lat), 32'(4 + int'(sel)));
    chk({tag, "_busy_cycles"}, 32'(bc), 32'(4 + int'(sel)));
    chk({tag, "_y"}, 32'(o_y), 32'(ey));
    cyc(1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b1);
    chk({tag, "_idle_after"}, 32'({o_busy, o_valid}), 32'd0);
  endtask

  task automatic directed();
    logic [22:0] ey;
    logic [11:0] ta [3];
    logic [11:0] tb [3];
    int t [3];
    int k;
    int n;
    logic seen;

    cyc(1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_out_valid", 32'(o_valid), 32'd0);
    chk("rst_y", 32'(o_y), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_core", 32'({o_ca, o_cb}), 32'd0);
    chk("rst_in_ready", 32'(o_ready), 32'd1);

    op(12'h001, 12'h001, 23'h000001, "T1");
    op(12'hFFF, 12'h003, 23'h001001, "T2a");
    op(12'h840, 12'h840, 23'h401000, "T2b");

    cyc(1'b1, 12'h123, 12'h456, 1'b0, 1'b0, 1'b1);
    wait_valid("T3_valid");
    ey = clmul12(12'h123, 12'h456);
    for (int i = 0; i < 10; i++) begin
      chk("T3_hold_valid", 32'(o_valid), 32'd1);
      chk("T3_hold_y", 32'(o_y), 32'(ey));
      chk("T3_hold_in_ready", 32'(o_ready), 32'd0);
      cyc(1'b0, 12'hFFF, 12'hFFF, 1'b0, 1'b0, 1'b1);
    end
    cyc(1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b1);
    chk("T3_retired", 32'(o_valid), 32'd0);
    chk("T3_queue", 32'(q.size()), 32'd0);

    ta[0] = 12'hABC; tb[0] = 12'h5A5;
    ta[1] = 12'hFFF; tb[1] = 12'hFFF;
    ta[2] = 12'h03F; tb[2] = 12'hFC0;
    k = 0;
    n = 0;
    while (k < 3 && n < 40) begin
      cyc(1'b1, ta[k], tb[k], 1'b1, 1'b0, 1'b1);
      if (accepted) begin
        t[k] = ncyc;
        k++;
      end
      n++;
    end
    chk("T4_accepts", 32'(k), 32'd3);
    if (k == 3) begin
      chk("T4_gap01", 32'(t[1] - t[0]), 32'(4 + int'(sel)));
      chk("T4_gap12", 32'(t[2] - t[1]), 32'(4 + int'(sel)));
    end
    n = 0;
    while (q.size() > 0 && n < 20) begin
      cyc(1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b1);
      n++;
    end
    chk("T4_drained", 32'(q.size()), 32'd0);

    cyc(1'b1, 12'hFFF, 12'hFFF, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b1);
    chk("T5a_busy", 32'(o_busy), 32'd0);
    chk("T5a_core", 32'({o_ca, o_cb}), 32'd0);
    chk("T5a_in_ready", 32'(o_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | o_valid;
      cyc(1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 1'b1);
    end
    chk("T5a_no_valid", 32'(seen), 32'd0);
    op(12'hFFF, 12'h003, 23'h001001, "T5a_next");

    cyc(1'b1, 12'h007, 12'h009, 1'b0, 1'b0, 1'b1);
    wait_valid("T5b_valid");
    cyc(1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b1);
    chk("T5b_dropped", 32'({o_valid, o_busy}), 32'd0);
    op(12'h001, 12'h001, 23'h000001, "T5b_next");

    cyc(1'b1, 12'hABC, 12'hDEF, 1'b0, 1'b0, 1'b1);
    idle(2);
    cyc(1'b1, 12'h111, 12'h111, 1'b1, 1'b1, 1'b0);
    chk("T6_out_valid", 32'(o_valid), 32'd0);
    chk("T6_y", 32'(o_y), 32'd0);
    chk("T6_busy", 32'(o_busy), 32'd0);
    chk("T6_core", 32'({o_ca, o_cb}), 32'd0);
    chk("T6_in_ready", 32'(o_ready), 32'd1);
    op(12'h840, 12'h840, 23'h401000, "T6_next");
  endtask

  task automatic random_run(input int nops);
    int k;
    int n;
    logic v;
    logic r;
    k = 0;
    n = 0;
    while ((k < nops || q.size() > 0) && n < 40000) begin
      v = (k < nops) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      cyc(v, 12'($urandom), 12'($urandom), r, 1'b0, 1'b1);
      if (accepted) k++;
      n++;
    end
    chk("rand_accepts", 32'(k), 32'(nops));
    chk("rand_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    sel = 1'b0; iv = 1'b0; orv = 1'b0; av = '0; bv = '0;
    flush = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    directed();
    random_run(2500);
    sel = 1'b1;
    directed();
    random_run(2500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
